// File: rtl/divider_pkg.sv
// Shared definitions for the RV32M iterative divider: op encodings, width, FSM states.
package divider_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // op equals funct3[1:0] of the M-extension divide instructions
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !((op == OP_DIVU) || (op == OP_REMU));
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return !((op == OP_DIV) || (op == OP_DIVU));
  endfunction

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] div_i,
  input  logic            bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Remainder stays below the divisor, so a non-negative difference fits in XLEN
  // bits and bit XLEN of the trial difference is exactly the borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    trial   = shifted - {1'b0, div_i};
    qbit_o  = ~trial[XLEN];
    rem_o   = qbit_o ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/divider.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), start/busy/done handshake.
// Optional macro DIVIDER_FASTPATH_EN: divide-by-zero and signed overflow skip the 32 steps.
module divider
  import divider_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_lat_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic            qneg_q;
  logic            rneg_q;
  logic            div0_q;
  logic            ovf_q;
  logic [CW-1:0]   cnt_q;
  logic            done_q;
  logic            we_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_out_q;

  logic            in_signed;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            in_div0;
  logic            in_ovf;
  logic            fast_go;
  logic [XLEN-1:0] step_rem;
  logic            step_qbit;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] result_d;

  always_comb begin
    in_signed = op_is_signed(op);
    abs_a     = (in_signed && a[XLEN-1]) ? -a : a;
    abs_b     = (in_signed && b[XLEN-1]) ? -b : b;
    in_div0   = (b == '0);
    in_ovf    = in_signed && (a == MIN_NEG) && (b == '1);
  end

`ifdef DIVIDER_FASTPATH_EN
  assign fast_go = in_div0 | in_ovf;
`else
  assign fast_go = 1'b0;
`endif

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (rem_q),
    .div_i  (dvs_q),
    .bit_i  (dvd_q[XLEN-1]),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  // Special cases override the sign fix; the fast path leaves quo/rem stale, so
  // those results must come only from the latched raw dividend and constants.
  always_comb begin
    quo_fix = qneg_q ? -quo_q : quo_q;
    rem_fix = rneg_q ? -rem_q : rem_q;
    if (div0_q) begin
      quo_fix = '1;
      rem_fix = a_q;
    end else if (ovf_q) begin
      quo_fix = MIN_NEG;
      rem_fix = '0;
    end
    result_d = op_is_rem(op_q) ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_lat_q <= '0;
      a_q      <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      done_q <= 1'b0;
      we_q   <= 1'b0;
      if (kill) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start) begin
              op_q     <= op;
              rd_lat_q <= rd_in;
              a_q      <= a;
              dvd_q    <= abs_a;
              dvs_q    <= abs_b;
              qneg_q   <= in_signed && (a[XLEN-1] ^ b[XLEN-1]);
              rneg_q   <= in_signed && a[XLEN-1];
              div0_q   <= in_div0;
              ovf_q    <= in_ovf;
              rem_q    <= '0;
              cnt_q    <= CW'(XLEN - 1);
              state_q  <= fast_go ? S_FIN : S_CALC;
            end
          end
          S_CALC: begin
            rem_q <= step_rem;
            quo_q <= {quo_q[XLEN-2:0], step_qbit};
            dvd_q <= {dvd_q[XLEN-2:0], 1'b0};
            if (cnt_q == '0) begin
              state_q <= S_FIN;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_FIN: begin
            result_q <= result_d;
            rd_out_q <= rd_lat_q;
            done_q   <= 1'b1;
            we_q     <= (rd_lat_q != '0);
            state_q  <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign we_out = we_q;
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: cycle-level reference model plus directed and random stimulus.
module tb_divider;

  logic        clk = 1'b0;
  logic        rst, start, kill;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  divider #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .rd_out (rd_out),
    .we_out (we_out)
  );

`ifdef DIVIDER_FASTPATH_EN
  localparam int FAST = 2;
`else
  localparam int FAST = 34;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    int  sx, sy;
    logic ovf;
    sx  = x;
    sy  = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      2'b00: if (y == 0) return 32'hFFFF_FFFF; else if (ovf) return x; else return sx / sy;
      2'b01: if (y == 0) return 32'hFFFF_FFFF; else return x / y;
      2'b10: if (y == 0) return x; else if (ovf) return 32'h0; else return sx % sy;
      default: if (y == 0) return x; else return x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic special;
    special = (y == 0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
    return special ? FAST : 34;
  endfunction

  // Model: one pending op with the cycle its done is due; held result/rd after each done.
  bit          m_valid = 1'b0;
  bit          m_pend  = 1'b0;
  int          m_done_cyc;
  logic [31:0] m_res, h_res;
  logic [4:0]  m_rd, h_rd;
  bit          e_busy, e_done;

  always @(negedge clk) begin
    e_busy = m_pend && (cyc < m_done_cyc);
    e_done = m_pend && (cyc == m_done_cyc);
    if (m_valid) begin
      if (e_done) begin
        h_res = m_res;
        h_rd  = m_rd;
      end
      chk("busy",   {31'b0, busy},   {31'b0, e_busy});
      chk("done",   {31'b0, done},   {31'b0, e_done});
      chk("we_out", {31'b0, we_out}, {31'b0, e_done && (h_rd != 0)});
      chk("result", result, h_res);
      chk("rd_out", {27'b0, rd_out}, {27'b0, h_rd});
    end
    if (rst) begin
      m_valid = 1'b1;
      m_pend  = 1'b0;
      h_res   = '0;
      h_rd    = '0;
    end else if (m_valid) begin
      if (e_done) m_pend = 1'b0;
      if (kill) begin
        m_pend = 1'b0;
      end else if (start && !e_busy) begin
        m_pend     = 1'b1;
        m_done_cyc = cyc + ref_lat(op, a, b);
        m_res      = ref_div(op, a, b);
        m_rd       = rd_in;
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [4:0] r, input logic [31:0] er, input int el);
    int s;
    bit seen;
    seen  = 1'b0;
    op    = o;
    a     = x;
    b     = y;
    rd_in = r;
    start = 1'b1;
    s     = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout op %0d: got no done, expected one within 40 cycles", o);
    end else begin
      chk("latency", cyc - s, el);
      chk("op_result", result, er);
      chk("op_rd_out", {27'b0, rd_out}, {27'b0, r});
      chk("op_we_out", {31'b0, we_out}, {31'b0, r != 0});
    end
  endtask

  initial begin
    int s;
    int rsel;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("pin_divu", ref_div(2'b01, 100, 7), 32'd14);
    chk("pin_remu", ref_div(2'b11, 100, 7), 32'd2);
    chk("pin_div",  ref_div(2'b00, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("pin_rem",  ref_div(2'b10, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);

    do_op(2'b01, 100, 7, 5'd5, 32'd14, 34);
    do_op(2'b11, 100, 7, 5'd5, 32'd2, 34);
    do_op(2'b00, 32'hFFFF_FFF9, 2, 5'd7, 32'hFFFF_FFFD, 34);
    do_op(2'b10, 32'hFFFF_FFF9, 2, 5'd7, 32'hFFFF_FFFF, 34);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h8000_0000, FAST);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1, 32'h0, FAST);
    do_op(2'b01, 5, 0, 5'd3, 32'hFFFF_FFFF, FAST);
    do_op(2'b11, 5, 0, 5'd3, 32'd5, FAST);
    do_op(2'b00, 32'hFFFF_FFF9, 0, 5'd4, 32'hFFFF_FFFF, FAST);
    do_op(2'b10, 32'hFFFF_FFF9, 0, 5'd4, 32'hFFFF_FFF9, FAST);
    // rd=0, then a second start in the same cycle done is high
    do_op(2'b01, 8, 2, 5'd0, 32'd4, 34);
    do_op(2'b01, 9, 3, 5'd6, 32'd3, 34);

    // kill in cycle 10 of a DIV, new DIVU started in cycle 11
    op = 2'b00; a = 1000; b = 3; rd_in = 5'd9; start = 1'b1; s = cyc;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    chk("kill_busy", {31'b0, busy}, 32'd0);
    chk("kill_cycle", cyc - s, 32'd11);
    do_op(2'b01, 9, 3, 5'd10, 32'd3, 34);
    chk("kill_done_cycle", cyc - s, 32'd45);

    // reset in cycle 20 of an operation
    op = 2'b01; a = 32'h1234_5678; b = 13; rd_in = 5'd11; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_done",   {31'b0, done},   32'd0);
    chk("rst_we",     {31'b0, we_out}, 32'd0);
    chk("rst_result", result,          32'd0);
    repeat (40) begin @(posedge clk); #1; end

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 2) == 0);
      kill  = ($urandom_range(0, 79) == 0);
      rst   = ($urandom_range(0, 499) == 0);
      op    = 2'($urandom_range(0, 3));
      rd_in = 5'($urandom_range(0, 31));
      a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rsel  = $urandom_range(0, 9);
      case (rsel)
        0:       b = 32'h0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = $urandom_range(1, 20);
        3:       b = -($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      @(posedge clk); #1;
    end
    start = 1'b0; kill = 1'b0; rst = 1'b0;
    repeat (40) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
